write_buffer: RTL and testbench

Byte-to-word packer on the memory write path, the mirror of the word-to-byte read path. Accepts a stream of bytes from the telemetry or command logic and packs each pair into a 16-bit word, low byte first. Holds one completed word while assembling the next. Issues a level-held write command to the memory controller, which clears it with a one-cycle done strobe.

---
 rtl/avionics_pkg.sv | 16 +
 rtl/write_buffer_if.sv | 24 ++
 rtl/write_buffer.sv | 106 ++++++++++
 tb/tb_write_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/avionics_pkg.sv
// rtl/avionics_pkg.sv - shared avionics definitions for the byte/word memory paths
package avionics_pkg;

    typedef enum logic {
        WB_EMPTY   = 1'b0,
        WB_HAVE_LO = 1'b1
    } wb_state_e;

    localparam logic [7:0] WB_PAD_BYTE_DEFAULT = 8'h00;

    // Low byte first: the first byte of a pair lands in bits [7:0].
    function automatic logic [15:0] wb_pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// rtl/write_buffer_if.sv - byte-in / word-write bundle of the write buffer
interface write_buffer_if #(
    parameter int CNT_W = 16
);
    logic             BYTE_VALID;
    logic [7:0]       BYTE_IN;
    logic             FLUSH;
    logic             WRITE_DONE;
    logic             BYTE_READY;
    logic             WRITE_CMD;
    logic [15:0]      DATA_WRITE;
    logic             OVERFLOW;
    logic [CNT_W-1:0] WORDS_WRITTEN;

    modport master (
        output BYTE_VALID, BYTE_IN, FLUSH, WRITE_DONE,
        input  BYTE_READY, WRITE_CMD, DATA_WRITE, OVERFLOW, WORDS_WRITTEN
    );

    modport slave (
        input  BYTE_VALID, BYTE_IN, FLUSH, WRITE_DONE,
        output BYTE_READY, WRITE_CMD, DATA_WRITE, OVERFLOW, WORDS_WRITTEN
    );
endinterface

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - packs byte pairs into 16-bit words and issues held write commands
module write_buffer
    import avionics_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = WB_PAD_BYTE_DEFAULT,
    parameter int         CNT_W    = 16
) (
    input  logic          CLK_48MHZ,
    input  logic          RESET,
    write_buffer_if.slave bus
);

    wb_state_e        state_q, state_d;
    logic [7:0]       lo_q, lo_d;
    logic             pending_q, pending_d;
    logic [15:0]      data_q, data_d;
    logic             flush_req_q, flush_req_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic      byte_ready;
    logic      accept;
    logic      stage_free;
    logic      load;
    logic [15:0] word;
    wb_state_e state_after_byte;

    // A second byte can only be refused when it would complete a word with nowhere to go.
    assign byte_ready = !(pending_q && (state_q == WB_HAVE_LO) && !bus.WRITE_DONE) && !flush_req_q;
    assign accept     = bus.BYTE_VALID && byte_ready;
    assign stage_free = !pending_q || bus.WRITE_DONE;

    always_comb begin
        state_d          = state_q;
        lo_d             = lo_q;
        pending_d        = pending_q;
        data_d           = data_q;
        flush_req_d      = flush_req_q;
        overflow_d       = overflow_q;
        count_d          = count_q;
        load             = 1'b0;
        word             = data_q;
        state_after_byte = state_q;

        if (accept) begin
            if (state_q == WB_EMPTY) begin
                lo_d             = bus.BYTE_IN;
                state_after_byte = WB_HAVE_LO;
            end else begin
                load             = 1'b1;
                word             = wb_pack_word(bus.BYTE_IN, lo_q);
                state_after_byte = WB_EMPTY;
            end
        end else if (bus.BYTE_VALID) begin
            overflow_d = 1'b1;
        end
        state_d = state_after_byte;

        // Flush acts on the state left after this cycle's byte, so a byte plus flush pads at once.
        if (bus.FLUSH && (state_after_byte == WB_HAVE_LO)) begin
            flush_req_d = 1'b1;
        end
        if (flush_req_d && (state_after_byte == WB_HAVE_LO) && stage_free && !load) begin
            load        = 1'b1;
            word        = wb_pack_word(PAD_BYTE, lo_d);
            state_d     = WB_EMPTY;
            flush_req_d = 1'b0;
        end

        if (bus.WRITE_DONE && pending_q) begin
            pending_d = 1'b0;
            count_d   = count_q + CNT_W'(1);
        end
        if (load) begin
            pending_d = 1'b1;
            data_d    = word;
        end
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q     <= WB_EMPTY;
            lo_q        <= 8'h00;
            pending_q   <= 1'b0;
            data_q      <= 16'h0000;
            flush_req_q <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            pending_q   <= pending_d;
            data_q      <= data_d;
            flush_req_q <= flush_req_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
        end
    end

    assign bus.BYTE_READY    = byte_ready;
    assign bus.WRITE_CMD     = pending_q;
    assign bus.DATA_WRITE    = data_q;
    assign bus.OVERFLOW      = overflow_q;
    assign bus.WORDS_WRITTEN = count_q;

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - self-checking bench for write_buffer
module tb_write_buffer;

    localparam logic [7:0] PAD = 8'h00;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    write_buffer_if #(.CNT_W(4)) bus ();

    write_buffer #(.PAD_BYTE(PAD), .CNT_W(4)) dut (
        .CLK_48MHZ(clk),
        .RESET    (rst_n),
        .bus      (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic got_rdy;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] b, input logic f, input logic d);
        @(negedge clk);
        bus.BYTE_VALID = v;
        bus.BYTE_IN    = b;
        bus.FLUSH      = f;
        bus.WRITE_DONE = d;
        #1 got_rdy = bus.BYTE_READY;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.BYTE_VALID = 1'b0;
        bus.FLUSH      = 1'b0;
        bus.WRITE_DONE = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk({tag, "_cmd"},  32'(bus.WRITE_CMD),     32'd0);
        chk({tag, "_data"}, 32'(bus.DATA_WRITE),    32'h0000);
        chk({tag, "_rdy"},  32'(bus.BYTE_READY),    32'd1);
        chk({tag, "_ovf"},  32'(bus.OVERFLOW),      32'd0);
        chk({tag, "_cnt"},  32'(bus.WORDS_WRITTEN), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: bytes waiting to be paired, words waiting to be acknowledged.
    logic [7:0]  held[$];
    logic [15:0] outq[$];
    logic        m_fr, m_ovf;
    logic [15:0] m_data;
    int          m_cnt;

    task automatic m_reset();
        held.delete();
        outq.delete();
        m_fr   = 1'b0;
        m_ovf  = 1'b0;
        m_data = 16'h0000;
        m_cnt  = 0;
    endtask

    function automatic logic m_ready(input logic d);
        return !(outq.size() == 1 && held.size() == 1 && !d) && !m_fr;
    endfunction

    task automatic m_push(input logic [15:0] w);
        outq.push_back(w);
        m_data = w;
    endtask

    task automatic m_step(input logic v, input logic [7:0] b, input logic f, input logic d);
        logic rdy;
        rdy = m_ready(d);
        if (d && outq.size() > 0) begin
            void'(outq.pop_front());
            m_cnt++;
        end
        if (v) begin
            if (rdy) begin
                held.push_back(b);
                if (held.size() == 2) begin
                    m_push({held[1], held[0]});
                    held.delete();
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (f && held.size() == 1) m_fr = 1'b1;
        if (m_fr && held.size() == 1 && outq.size() == 0) begin
            m_push({PAD, held[0]});
            held.delete();
            m_fr = 1'b0;
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        f;
        logic        d;
        logic        e_rdy;
        logic        e_cmd;
        logic [15:0] e_data;
        logic        e_ovf;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic f, input logic d,
                                input logic rdy, input logic cmd, input logic [15:0] data,
                                input logic ovf, input logic [3:0] cnt);
        vec_t t;
        t.v = v; t.b = b; t.f = f; t.d = d;
        t.e_rdy = rdy; t.e_cmd = cmd; t.e_data = data; t.e_ovf = ovf; t.e_cnt = cnt;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  byte   f  d   rdy cmd data     ovf cnt
        tbl[0]  = mk(1, 8'hA1, 0, 0,  1,  0, 16'h0000, 0,  0);
        tbl[1]  = mk(1, 8'hB2, 0, 0,  1,  1, 16'hB2A1, 0,  0);
        tbl[2]  = mk(0, 8'h00, 0, 0,  1,  1, 16'hB2A1, 0,  0);
        tbl[3]  = mk(0, 8'h00, 0, 0,  1,  1, 16'hB2A1, 0,  0);
        tbl[4]  = mk(0, 8'h00, 0, 1,  1,  0, 16'hB2A1, 0,  1);
        tbl[5]  = mk(1, 8'h01, 0, 0,  1,  0, 16'hB2A1, 0,  1);
        tbl[6]  = mk(1, 8'h02, 0, 0,  1,  1, 16'h0201, 0,  1);
        tbl[7]  = mk(1, 8'h03, 0, 0,  1,  1, 16'h0201, 0,  1);
        tbl[8]  = mk(1, 8'h04, 0, 0,  0,  1, 16'h0201, 1,  1);
        tbl[9]  = mk(1, 8'h04, 0, 1,  1,  1, 16'h0403, 1,  2);
        tbl[10] = mk(0, 8'h00, 0, 1,  1,  0, 16'h0403, 1,  3);
        tbl[11] = mk(1, 8'h5A, 0, 0,  1,  0, 16'h0403, 1,  3);
        tbl[12] = mk(0, 8'h00, 1, 0,  1,  1, 16'h005A, 1,  3);
        tbl[13] = mk(0, 8'h00, 1, 0,  1,  1, 16'h005A, 1,  3);
        tbl[14] = mk(0, 8'h00, 0, 1,  1,  0, 16'h005A, 1,  4);
        tbl[15] = mk(0, 8'h00, 1, 0,  1,  0, 16'h005A, 1,  4);
        tbl[16] = mk(1, 8'h11, 0, 0,  1,  0, 16'h005A, 1,  4);
        tbl[17] = mk(1, 8'h22, 0, 0,  1,  1, 16'h2211, 1,  4);
        tbl[18] = mk(1, 8'h33, 0, 0,  1,  1, 16'h2211, 1,  4);
        tbl[19] = mk(0, 8'h00, 1, 0,  0,  1, 16'h2211, 1,  4);
        tbl[20] = mk(0, 8'h00, 0, 0,  0,  1, 16'h2211, 1,  4);
        tbl[21] = mk(0, 8'h00, 0, 1,  0,  1, 16'h0033, 1,  5);
        tbl[22] = mk(0, 8'h00, 0, 0,  1,  1, 16'h0033, 1,  5);
        tbl[23] = mk(0, 8'h00, 0, 1,  1,  0, 16'h0033, 1,  6);

        rst_n          = 1'b0;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN    = 8'h00;
        bus.FLUSH      = 1'b0;
        bus.WRITE_DONE = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].f, tbl[i].d);
            chk($sformatf("vec%0d_rdy", i),  32'(got_rdy),           32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_cmd", i),  32'(bus.WRITE_CMD),     32'(tbl[i].e_cmd));
            chk($sformatf("vec%0d_data", i), 32'(bus.DATA_WRITE),    32'(tbl[i].e_data));
            chk($sformatf("vec%0d_ovf", i),  32'(bus.OVERFLOW),      32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_cnt", i),  32'(bus.WORDS_WRITTEN), 32'(tbl[i].e_cnt));
        end

        // Reset with a low byte held and a word pending: nothing survives.
        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 0, 0);
        cyc(1, 8'hCC, 0, 0);
        chk("midrst_pre_cmd", 32'(bus.WRITE_CMD), 32'd1);
        do_reset("midrst");
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 0, 0);
            chk($sformatf("midrst_idle%0d_cmd", i), 32'(bus.WRITE_CMD), 32'd0);
        end
        chk("midrst_idle_data", 32'(bus.DATA_WRITE), 32'h0000);

        // Counter wrap with a 4-bit counter.
        for (int k = 0; k < 17; k++) begin
            cyc(1, 8'(2 * k), 0, 0);
            cyc(1, 8'(2 * k + 1), 0, 0);
            cyc(0, 8'h00, 0, 1);
        end
        chk("wrap_cnt", 32'(bus.WORDS_WRITTEN), 32'd1);
        chk("wrap_cmd", 32'(bus.WRITE_CMD),     32'd0);

        // Random traffic against the queue model, with occasional resets.
        do_reset("rnd_reset");
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       v, f, d, er;
            logic [7:0] b;
            v  = ($urandom_range(0, 9) < 7);
            b  = 8'($urandom);
            f  = ($urandom_range(0, 11) == 0);
            d  = ($urandom_range(0, 9) < 4);
            er = m_ready(d);
            cyc(v, b, f, d);
            m_step(v, b, f, d);
            chk("rnd_rdy",  32'(got_rdy),           32'(er));
            chk("rnd_cmd",  32'(bus.WRITE_CMD),     32'(outq.size() != 0));
            chk("rnd_data", 32'(bus.DATA_WRITE),    32'(m_data));
            chk("rnd_ovf",  32'(bus.OVERFLOW),      32'(m_ovf));
            chk("rnd_cnt",  32'(bus.WORDS_WRITTEN), 32'(m_cnt % 16));
            if (i % 700 == 699) begin
                do_reset("rnd_midrst");
                m_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
